stack_ctl: RTL and testbench

- Request sequencer directly upstream of the shift-register data/return stack.
- Converts core push/pop/replace/bulk-drop requests into the stack's `we`/`delta`/`wd`/`hold` controls.
- Tracks occupancy, high-water mark and sticky overflow/underflow errors for the debug port.
- Multi-cycle DROPN/CLEAR operations are sequenced here, one stack move per cycle, with ready/valid backpressure to the core.

---
 rtl/stack_pkg.sv | 40 ++++
 rtl/stack_ctl.sv | 209 ++++++++++++++++++++
 tb/tb_stack_ctl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack request sequencer and anything else that
// talks to the shift-register stack (stack instance, debug register map).
//   - op_e      : request operation codes on req_op
//   - DELTA_*   : encodings of the stack's delta control
//   - state_e   : sequencer FSM states
//   - cap_of()  : stack capacity (head + tail) for a given tail depth
//   - dw_of()   : occupancy counter width able to hold 0..capacity
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_REPL  = 3'd3,
        OP_DROPN = 3'd4,
        OP_CLEAR = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    localparam logic [1:0] DELTA_NONE = 2'b00;
    localparam logic [1:0] DELTA_UP   = 2'b01;
    localparam logic [1:0] DELTA_DOWN = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BULK = 1'b1
    } state_e;

    // Capacity counts the head register plus the tail.
    function automatic int cap_of(input int depth_p);
        return depth_p + 1;
    endfunction

    // Counter must represent 0..cap inclusive, i.e. depth+2 distinct values.
    function automatic int dw_of(input int depth_p);
        return $clog2(depth_p + 2);
    endfunction

endpackage

// File: rtl/stack_ctl.sv
// stack_ctl: request sequencer in front of the shift-register stack.
// Turns core PUSH/POP/REPL/DROPN/CLEAR requests into the stack's we/delta/wd
// controls, sequences multi-pop operations one move per cycle, and keeps
// occupancy, high-water mark and sticky overflow/underflow flags.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hold                  core stall, freezes this block and the stack
//   req_valid/req_ready   request handshake
//   req_op/req_data/req_n operation, write data, drop count
//   st_we/st_delta/st_wd  stack controls (combinational, sampled same edge)
//   st_hold               stall forwarded to the stack
//   depth/empty/full/hwm  occupancy status
//   ovf/unf/err_clr       sticky error flags and their clear pulse
module stack_ctl
    import stack_pkg::*;
#(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 16,
    localparam int DW    = dw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [DW-1:0]    req_n,
    output logic             st_we,
    output logic [1:0]       st_delta,
    output logic [WIDTH-1:0] st_wd,
    output logic             st_hold,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic [DW-1:0]    hwm,
    output logic             ovf,
    output logic             unf,
    input  logic             err_clr
);

    localparam logic [DW-1:0] CAP_V = DW'(cap_of(DEPTH));
    localparam logic [DW-1:0] ONE_V = DW'(1);

    state_e            state_r;
    logic [DW-1:0]     cnt_r;
    logic [DW-1:0]     depth_r;
    logic [DW-1:0]     hwm_r;
    logic              ovf_r;
    logic              unf_r;

    op_e               op_s;
    logic              accept_s;
    logic              we_s;
    logic [1:0]        delta_s;
    logic [WIDTH-1:0]  wd_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic [DW-1:0]     load_cnt_s;
    logic [DW-1:0]     depth_nxt_s;
    logic              ovf_set_s;
    logic              unf_set_s;

    assign op_s      = op_e'(req_op);
    // rst_n is folded in so the core sees no acceptance while reset is held.
    assign req_ready = rst_n & ~hold & (state_r == ST_IDLE);
    assign accept_s  = req_valid & req_ready;

    // Decode the accepted request (or the ongoing bulk pop) into a stack move.
    always_comb begin
        we_s       = 1'b0;
        delta_s    = DELTA_NONE;
        wd_s       = '0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        load_s     = 1'b0;
        load_cnt_s = '0;
        if (rst_n && !hold && (state_r == ST_BULK)) begin
            delta_s = DELTA_DOWN;
            pop_s   = 1'b1;
        end else if (accept_s) begin
            case (op_s)
                OP_PUSH: begin
                    we_s    = 1'b1;
                    delta_s = DELTA_UP;
                    wd_s    = req_data;
                    push_s  = 1'b1;
                end
                OP_POP: begin
                    delta_s = DELTA_DOWN;
                    pop_s   = 1'b1;
                end
                OP_REPL: begin
                    we_s = 1'b1;
                    wd_s = req_data;
                end
                OP_DROPN: begin
                    // First pop goes out with the accept; cnt holds the rest.
                    if (req_n != '0) begin
                        delta_s    = DELTA_DOWN;
                        pop_s      = 1'b1;
                        load_s     = 1'b1;
                        load_cnt_s = req_n - ONE_V;
                    end else begin
                        load_s = 1'b0;
                    end
                end
                OP_CLEAR: begin
                    if (depth_r != '0) begin
                        delta_s    = DELTA_DOWN;
                        pop_s      = 1'b1;
                        load_s     = 1'b1;
                        load_cnt_s = depth_r - ONE_V;
                    end else begin
                        load_s = 1'b0;
                    end
                end
                default: begin
                    we_s = 1'b0;
                end
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Next occupancy; the stack still moves at the limits, only the count saturates.
    always_comb begin
        depth_nxt_s = depth_r;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        if (push_s) begin
            if (depth_r == CAP_V) begin
                ovf_set_s = 1'b1;
            end else begin
                depth_nxt_s = depth_r + ONE_V;
            end
        end else if (pop_s) begin
            if (depth_r == '0) begin
                unf_set_s = 1'b1;
            end else begin
                depth_nxt_s = depth_r - ONE_V;
            end
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    // Sequencer FSM plus occupancy, high-water and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            depth_r <= '0;
            hwm_r   <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (!hold) begin
            depth_r <= depth_nxt_s;
            // err_clr wins over a same-cycle set and reloads hwm from the new depth.
            if (err_clr) begin
                hwm_r <= depth_nxt_s;
                ovf_r <= 1'b0;
                unf_r <= 1'b0;
            end else begin
                hwm_r <= (depth_nxt_s > hwm_r) ? depth_nxt_s : hwm_r;
                ovf_r <= ovf_r | ovf_set_s;
                unf_r <= unf_r | unf_set_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        cnt_r   <= load_cnt_s;
                        state_r <= (load_cnt_s != '0) ? ST_BULK : ST_IDLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BULK: begin
                    cnt_r <= cnt_r - ONE_V;
                    if (cnt_r == ONE_V) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BULK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign st_we    = we_s;
    assign st_delta = delta_s;
    assign st_wd    = wd_s;
    assign st_hold  = hold;
    assign depth    = depth_r;
    assign empty    = (depth_r == '0);
    assign full     = (depth_r == CAP_V);
    assign hwm      = hwm_r;
    assign ovf      = ovf_r;
    assign unf      = unf_r;

endmodule

// File: tb/tb_stack_ctl.sv
// Testbench for stack_ctl: directed scenarios followed by random requests.
// Expected stack moves go into a queue when a request is accepted; a monitor
// on the falling edge pops and compares every move the DUT presents. The
// reference model keeps the stack contents as a queue of values.
module tb_stack_ctl;
    import stack_pkg::*;

    localparam int WIDTH = 18;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 1;
    localparam int DW    = $clog2(DEPTH + 2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hold;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic [DW-1:0]    req_n;
    logic             st_we;
    logic [1:0]       st_delta;
    logic [WIDTH-1:0] st_wd;
    logic             st_hold;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic [DW-1:0]    hwm;
    logic             ovf;
    logic             unf;
    logic             err_clr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic             we;
        logic [1:0]       delta;
        logic [WIDTH-1:0] wd;
    } move_t;

    move_t            exp_q[$];
    logic [WIDTH-1:0] mdl[$];
    int               m_hwm;
    int               m_ovf;
    int               m_unf;

    stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_n(req_n),
        .st_we(st_we), .st_delta(st_delta), .st_wd(st_wd), .st_hold(st_hold),
        .depth(depth), .empty(empty), .full(full), .hwm(hwm),
        .ovf(ovf), .unf(unf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic move_t mk_move(input logic we, input logic [1:0] dl, input logic [WIDTH-1:0] d);
        move_t m;
        m.we    = we;
        m.delta = dl;
        m.wd    = d;
        return m;
    endfunction

    // Monitor: every move presented by the DUT must match the next expected one.
    always @(negedge clk) begin
        move_t e;
        if (rst_n === 1'b1) begin
            chk("st_hold", int'(st_hold), int'(hold));
            if (st_we || (st_delta != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_move: got we=%0b delta=%0b none expected", st_we, st_delta);
                end else begin
                    e = exp_q.pop_front();
                    chk("move_we", int'(st_we), int'(e.we));
                    chk("move_delta", int'(st_delta), int'(e.delta));
                    if (e.we) chk("move_wd", int'(st_wd), int'(e.wd));
                end
            end
        end
    end

    task automatic model_pop();
        exp_q.push_back(mk_move(1'b0, 2'b10, '0));
        if (mdl.size() > 0) void'(mdl.pop_front());
        else m_unf = 1;
    endtask

    // Apply one accepted request to the model; returns the number of stack moves.
    task automatic model_op(input logic [2:0] op, input logic [WIDTH-1:0] d, input int n, output int nm);
        int k;
        nm = 0;
        case (op)
            3'd1: begin
                exp_q.push_back(mk_move(1'b1, 2'b01, d));
                if (mdl.size() == CAP) begin
                    m_ovf = 1;
                    void'(mdl.pop_back());
                end
                mdl.push_front(d);
                nm = 1;
            end
            3'd2: begin
                model_pop();
                nm = 1;
            end
            3'd3: begin
                exp_q.push_back(mk_move(1'b1, 2'b00, d));
                if (mdl.size() > 0) mdl[0] = d;
                nm = 1;
            end
            3'd4: begin
                for (int i = 0; i < n; i++) model_pop();
                nm = n;
            end
            3'd5: begin
                k = mdl.size();
                for (int i = 0; i < k; i++) model_pop();
                nm = k;
            end
            default: nm = 0;
        endcase
        if (mdl.size() > m_hwm) m_hwm = mdl.size();
    endtask

    task automatic check_state();
        chk("depth", int'(depth), mdl.size());
        chk("empty", int'(empty), (mdl.size() == 0) ? 1 : 0);
        chk("full", int'(full), (mdl.size() == CAP) ? 1 : 0);
        chk("hwm", int'(hwm), m_hwm);
        chk("ovf", int'(ovf), m_ovf);
        chk("unf", int'(unf), m_unf);
    endtask

    // Issue one request and wait (bounded) for the sequencer to return idle.
    // hmode: 0 no stall, 1 stall on the first busy cycle, 2 random stalls.
    task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] d, input int n, input int hmode);
        int nm;
        int pops;
        int bound;
        bit first;
        bit h;
        @(posedge clk);
        #1;
        hold      = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_n     = DW'(n);
        #1;
        chk("req_ready_idle", int'(req_ready), 1);
        model_op(op, d, n, nm);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_data  = WIDTH'($urandom);
        req_n     = DW'($urandom);
        pops  = 0;
        bound = 0;
        first = 1'b1;
        while (1) begin
            hold = 1'b0;
            #1;
            if (req_ready) break;
            if (bound >= 200) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: op=%0d still busy after %0d cycles", op, bound);
                break;
            end
            h = ((hmode == 1) && first) || ((hmode == 2) && ($urandom_range(0, 3) == 0));
            first = 1'b0;
            hold = h;
            if (!h) pops++;
            bound++;
            @(posedge clk);
            #1;
        end
        chk("bulk_cycles", pops, (nm > 0) ? nm - 1 : 0);
        check_state();
    endtask

    task automatic do_err_clr();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_ovf = 0;
        m_unf = 0;
        m_hwm = mdl.size();
        check_state();
    endtask

    task automatic model_reset();
        mdl.delete();
        exp_q.delete();
        m_hwm = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        hold      = 1'b0;
        err_clr   = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_data  = 18'h1_2345;
        req_n     = '0;
        #12;
        // A request pending during reset must not reach the stack.
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_st_we", int'(st_we), 0);
        chk("rst_st_delta", int'(st_delta), 0);
        chk("rst_st_wd", int'(st_wd), 0);
        check_state();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three pushes, then pop and replace.
        do_op(3'd1, 18'h00001, 0, 0);
        do_op(3'd1, 18'h00002, 0, 0);
        do_op(3'd1, 18'h00003, 0, 0);
        do_op(3'd2, '0, 0, 0);
        do_op(3'd3, 18'h3FFFF, 0, 0);
        chk("model_head", int'(mdl[0]), 32'h3FFFF);

        // Fill past capacity, then clear errors.
        do_op(3'd5, '0, 0, 0);
        for (int i = 0; i < 18; i++) do_op(3'd1, WIDTH'(i + 16), 0, 0);
        do_err_clr();

        // DROPN 3 from depth 5 with one stall mid-operation.
        do_op(3'd5, '0, 0, 2);
        for (int i = 0; i < 5; i++) do_op(3'd1, WIDTH'($urandom), 0, 0);
        do_op(3'd4, '0, 3, 1);

        // DROPN 4 from depth 2 underflows; CLEAR at empty is a NOP.
        do_op(3'd4, '0, 4, 0);
        do_op(3'd5, '0, 0, 0);
        do_op(3'd4, '0, 0, 0);
        do_op(3'd6, '0, 0, 0);
        do_err_clr();

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 5) do_op(3'd1, WIDTH'($urandom), 0, 2);
            else if (r < 13) do_op(3'($urandom_range(0, 7)), WIDTH'($urandom), $urandom_range(0, 20), 2);
            else if (r < 14) do_op(3'd2, '0, 0, 2);
            else do_err_clr();
        end

        // Reset in the middle of a CLEAR from depth 10.
        do_op(3'd5, '0, 0, 0);
        for (int i = 0; i < 10; i++) do_op(3'd1, WIDTH'($urandom), 0, 0);
        @(posedge clk);
        #1;
        hold      = 1'b0;
        req_valid = 1'b1;
        req_op    = 3'd5;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_move(1'b0, 2'b10, '0));
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 3'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midbulk_rst_st_we", int'(st_we), 0);
        chk("midbulk_rst_st_delta", int'(st_delta), 0);
        chk("midbulk_rst_req_ready", int'(req_ready), 0);
        check_state();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", int'(req_ready), 1);
        do_op(3'd1, 18'h2AAAA, 0, 0);
        do_op(3'd2, '0, 0, 0);

        @(posedge clk);
        #1;
        chk("leftover_moves", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
